// File: rtl/movavg_pkg.sv
// Shared types and defaults for the moving-average crossing detector.
package movavg_pkg;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_ARM_HI,
        ST_HIGH,
        ST_ARM_LO
    } state_e;

    localparam int unsigned VAL_W    = 8;
    localparam int unsigned DEF_TS_W = 16;

    localparam logic signed [VAL_W-1:0] DEF_HI_THRESH = 8'sd32;
    localparam logic signed [VAL_W-1:0] DEF_LO_THRESH = -8'sd32;

    // Event record layout, MSB first: {dir, ts, value}
    function automatic int unsigned evt_width(input int unsigned ts_w);
        return 1 + ts_w + VAL_W;
    endfunction

endpackage

// File: rtl/movavg_event_fifo.sv
// Small register-based event FIFO; pointers carry one extra wrap bit for full/empty.
module movavg_event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        dout_o   = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din_i;
            end
        end
    end

endmodule

// File: rtl/movavg_crossing_detector.sv
// Hysteresis comparator with hold filter; timestamps confirmed crossings into an event FIFO.
module movavg_crossing_detector
    import movavg_pkg::*;
#(
    parameter logic signed [7:0] HI_THRESH   = DEF_HI_THRESH,
    parameter logic signed [7:0] LO_THRESH   = DEF_LO_THRESH,
    parameter int unsigned       HOLD_CYCLES = 4,
    parameter int unsigned       FIFO_DEPTH  = 4,
    parameter int unsigned       TS_WIDTH    = DEF_TS_W
) (
    input  logic                      system1000,
    input  logic                      system1000_rstn,
    input  logic signed [VAL_W-1:0]   avg_i,
    output logic                      evt_valid_o,
    input  logic                      evt_ready_i,
    output logic                      evt_dir_o,
    output logic [TS_WIDTH-1:0]       evt_ts_o,
    output logic signed [VAL_W-1:0]   evt_value_o,
    output logic                      level_o,
    output logic                      overflow_o
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned EVT_W = evt_width(TS_WIDTH);
    localparam logic [CNT_W-1:0] HOLD_N = CNT_W'(HOLD_CYCLES);

    if (LO_THRESH >= HI_THRESH) begin : g_bad_thresh
        $error("LO_THRESH must be below HI_THRESH");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("HOLD_CYCLES must be in 1..255");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                level_q, level_d;
    logic                ovf_q, ovf_d;
    logic                qual_hi, qual_lo;
    logic                push, push_dir;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EVT_W-1:0]    push_data, head_data;

    // Next-state, hold counter and event generation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        push_dir = 1'b0;
        qual_hi  = (avg_i >= HI_THRESH);
        qual_lo  = (avg_i <= LO_THRESH);
        cnt_inc  = cnt_q + CNT_W'(1);

        case (state_q)
            ST_LOW: begin
                if (qual_hi) begin
                    if (HOLD_N == CNT_W'(1)) begin
                        state_d  = ST_HIGH;
                        cnt_d    = '0;
                        push     = 1'b1;
                        push_dir = 1'b1;
                    end else begin
                        state_d = ST_ARM_HI;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_ARM_HI: begin
                if (!qual_hi) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_inc == HOLD_N) begin
                    state_d  = ST_HIGH;
                    cnt_d    = '0;
                    push     = 1'b1;
                    push_dir = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HIGH: begin
                if (qual_lo) begin
                    if (HOLD_N == CNT_W'(1)) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                        push    = 1'b1;
                    end else begin
                        state_d = ST_ARM_LO;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_ARM_LO: begin
                if (!qual_lo) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_inc == HOLD_N) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    push    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase

        level_d   = (state_d == ST_HIGH) || (state_d == ST_ARM_LO);
        ts_d      = ts_q + TS_WIDTH'(1);
        push_data = {push_dir, ts_q, avg_i};
        fifo_pop  = ~fifo_empty & evt_ready_i;
        fifo_push = push & (~fifo_full | fifo_pop);
        ovf_d     = ovf_q | (push & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            ts_q    <= '0;
            level_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    movavg_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (system1000),
        .rst_n   (system1000_rstn),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (push_data),
        .dout_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Event outputs come straight from the registered FIFO head
    always_comb begin
        evt_valid_o                          = ~fifo_empty;
        {evt_dir_o, evt_ts_o, evt_value_o}   = head_data;
        level_o                              = level_q;
        overflow_o                           = ovf_q;
    end

endmodule

// File: tb/tb_movavg_crossing_detector.sv
// Directed bench for movavg_crossing_detector with hand-computed expected events.
module tb_movavg_crossing_detector;

    localparam logic signed [7:0] P40 = 8'sd40;
    localparam logic signed [7:0] M40 = -8'sd40;
    localparam logic signed [7:0] M32 = -8'sd32;
    localparam logic signed [7:0] M31 = -8'sd31;
    localparam logic signed [7:0] Z0  = 8'sd0;

    logic              clk;
    logic              rst_n;
    logic signed [7:0] avg;
    logic              valid;
    logic              ready;
    logic              dir;
    logic [15:0]       ts;
    logic signed [7:0] value;
    logic              level;
    logic              ovf;

    int n_chk;
    int n_bad;
    int cyc;
    int seen;
    int last_ts;
    int first_ts;
    int pad;
    int exp_ts [5];

    movavg_crossing_detector dut (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .avg_i           (avg),
        .evt_valid_o     (valid),
        .evt_ready_i     (ready),
        .evt_dir_o       (dir),
        .evt_ts_o        (ts),
        .evt_value_o     (value),
        .level_o         (level),
        .overflow_o      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // cyc mirrors the DUT timestamp: the sample driven now is taken with ts == cyc
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic drive(input logic signed [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            avg     = v;
            last_ts = cyc;
            @(posedge clk);
            #1;
            cyc++;
            if (valid) seen++;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_dir"},   32'(dir), 0);
        check({tag, "_ts"},    32'(ts), 0);
        check({tag, "_value"}, {24'd0, value}, 0);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_ovf"},   32'(ovf), 0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        avg   = Z0;
        ready = 1'b1;
        cyc   = 0;
        seen  = 0;

        // Reset and idle input
        do_reset();
        check_zero("rst");
        drive(Z0, 50);
        check("idle_events", 32'(seen), 0);
        check("idle_level", 32'(level), 0);
        check("idle_ovf", 32'(ovf), 0);

        // Rising crossing at ts 10..13
        do_reset();
        seen = 0;
        drive(Z0, 10);
        drive(P40, 3);
        check("arm_hi_level", 32'(level), 0);
        check("arm_hi_valid", 32'(valid), 0);
        drive(P40, 1);
        check("rise_valid", 32'(valid), 1);
        check("rise_dir", 32'(dir), 1);
        check("rise_ts", 32'(ts), 13);
        check("rise_value", {24'd0, value}, 32'h28);
        check("rise_level", 32'(level), 1);
        drive(Z0, 1);
        check("rise_popped", 32'(valid), 0);
        check("rise_hold_level", 32'(level), 1);

        // Inside the band never confirms; exactly LO_THRESH does
        seen = 0;
        drive(M31, 4);
        check("band_events", 32'(seen), 0);
        check("band_level", 32'(level), 1);
        drive(M32, 3);
        check("arm_lo_level", 32'(level), 1);
        drive(M32, 1);
        check("fall_valid", 32'(valid), 1);
        check("fall_dir", 32'(dir), 0);
        check("fall_ts", 32'(ts), 32'(last_ts));
        check("fall_value", {24'd0, value}, 32'hE0);
        check("fall_level", 32'(level), 0);
        drive(Z0, 1);

        // A break in the run restarts the hold count
        seen = 0;
        drive(P40, 3);
        drive(Z0, 1);
        drive(P40, 3);
        check("broken_events", 32'(seen), 0);
        check("broken_level", 32'(level), 0);
        drive(P40, 1);
        check("rerun_valid", 32'(valid), 1);
        check("rerun_dir", 32'(dir), 1);
        check("rerun_ts", 32'(ts), 32'(last_ts));
        drive(Z0, 2);
        check("rerun_events", 32'(seen), 1);

        // Five crossings with no consumer: fifth is dropped
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive((i % 2 == 0) ? M40 : P40, 4);
            exp_ts[i] = last_ts;
            if (i == 3) check("ovf_before_drop", 32'(ovf), 0);
        end
        check("ovf_set", 32'(ovf), 1);
        check("full_valid", 32'(valid), 1);
        check("full_level", 32'(level), 0);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_valid", i), 32'(valid), 1);
            check($sformatf("drain%0d_dir", i), 32'(dir), (i % 2 == 0) ? 0 : 1);
            check($sformatf("drain%0d_ts", i), 32'(ts), 32'(exp_ts[i]));
            check($sformatf("drain%0d_value", i), {24'd0, value},
                  (i % 2 == 0) ? 32'hD8 : 32'h28);
            drive(Z0, 1);
        end
        check("drained_valid", 32'(valid), 0);
        check("ovf_sticky", 32'(ovf), 1);

        // Reset in ARM_HI with pending events at ts 0x1234
        ready = 1'b0;
        pad = 'h1234 - 10 - cyc;
        drive(Z0, pad);
        drive(P40, 4);
        first_ts = last_ts;
        drive(M40, 4);
        drive(P40, 2);
        check("pend_valid", 32'(valid), 1);
        check("pend_ts", 32'(ts), 32'(first_ts));
        check("pend_ovf", 32'(ovf), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        do_reset();
        ready = 1'b1;
        seen  = 0;
        drive(P40, 3);
        check("post_rst_events", 32'(seen), 0);
        check("post_rst_level", 32'(level), 0);
        drive(P40, 1);
        check("post_rst_valid", 32'(valid), 1);
        check("post_rst_ts", 32'(ts), 3);
        check("post_rst_value", {24'd0, value}, 32'h28);
        check("post_rst_ovf", 32'(ovf), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
